// File: rtl/triangle_pkg.sv
// Shared types for the triangle sweep tracker: FSM states, step classes and
// slope direction encodings.
package triangle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    RISING,
    FALLING
  } state_t;

  typedef enum logic [1:0] {
    STEP_UP,
    STEP_DOWN,
    STEP_HOLD,
    STEP_JUMP
  } step_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/triangle_step_cls.sv
// Classifies one sample step against the previous sample. The compare is done
// one bit wider so that all-ones -> 0 and 0 -> all-ones never look like +/-1.
module triangle_step_cls
  import triangle_pkg::*;
#(
  parameter int unsigned SIZE_POW2 = 10
) (
  input  logic [SIZE_POW2-1:0] prev_i,
  input  logic [SIZE_POW2-1:0] val_i,
  output step_t                step_o
);

  localparam logic [SIZE_POW2:0] One = (SIZE_POW2 + 1)'(1);

  logic [SIZE_POW2:0] prev_w;
  logic [SIZE_POW2:0] val_w;

  always_comb begin
    prev_w = {1'b0, prev_i};
    val_w  = {1'b0, val_i};
    if (val_w == prev_w + One) begin
      step_o = STEP_UP;
    end else if (val_w + One == prev_w) begin
      step_o = STEP_DOWN;
    end else if (val_w == prev_w) begin
      step_o = STEP_HOLD;
    end else begin
      step_o = STEP_JUMP;
    end
  end

endmodule

// File: rtl/triangle_tracker.sv
// Tracks a sampled triangle sweep: slope direction, peaks/troughs, half-period
// length between turning points, malformed steps and periodic lock.
module triangle_tracker
  import triangle_pkg::*;
#(
  parameter int unsigned SIZE_POW2 = 10,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [SIZE_POW2-1:0] val_i,
  output logic                 dir_o,
  output logic                 peak_o,
  output logic                 trough_o,
  output logic [SIZE_POW2-1:0] peak_val_o,
  output logic [SIZE_POW2-1:0] trough_val_o,
  output logic [CNT_W-1:0]     half_period_o,
  output logic                 err_o,
  output logic                 lock_o
);

  state_t               state_q;
  step_t                step;
  logic [SIZE_POW2-1:0] prev_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 seg_qual_q;   // current segment began at a turning point
  logic                 last_qual_q;  // half_period_o holds a qualified length
  logic                 lock_match;

  triangle_step_cls #(
    .SIZE_POW2(SIZE_POW2)
  ) u_step_cls (
    .prev_i(prev_q),
    .val_i (val_i),
    .step_o(step)
  );

  always_comb begin
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    lock_match = seg_qual_q && last_qual_q && (half_period_o == cnt_q);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      prev_q        <= '0;
      cnt_q         <= '0;
      seg_qual_q    <= 1'b0;
      last_qual_q   <= 1'b0;
      dir_o         <= 1'b0;
      peak_o        <= 1'b0;
      trough_o      <= 1'b0;
      peak_val_o    <= '0;
      trough_val_o  <= '0;
      half_period_o <= '0;
      err_o         <= 1'b0;
      lock_o        <= 1'b0;
    end else begin
      peak_o   <= 1'b0;
      trough_o <= 1'b0;
      err_o    <= 1'b0;
      if (valid_i) begin
        prev_q <= val_i;
        unique case (state_q)
          IDLE: state_q <= ACQ;
          ACQ: begin
            if (step == STEP_UP || step == STEP_DOWN) begin
              state_q    <= (step == STEP_UP) ? RISING : FALLING;
              dir_o      <= (step == STEP_UP) ? DIR_UP : DIR_DOWN;
              cnt_q      <= CNT_W'(1);
              seg_qual_q <= 1'b0;
            end
          end
          RISING, FALLING: begin
            if ((state_q == RISING && step == STEP_UP) ||
                (state_q == FALLING && step == STEP_DOWN)) begin
              cnt_q <= cnt_inc;
            end else if (step == STEP_UP || step == STEP_DOWN) begin
              if (state_q == RISING) begin
                peak_o     <= 1'b1;
                peak_val_o <= prev_q;
                state_q    <= FALLING;
                dir_o      <= DIR_DOWN;
              end else begin
                trough_o     <= 1'b1;
                trough_val_o <= prev_q;
                state_q      <= RISING;
                dir_o        <= DIR_UP;
              end
              half_period_o <= cnt_q;
              last_qual_q   <= seg_qual_q;
              lock_o        <= lock_match;
              cnt_q         <= CNT_W'(1);
              seg_qual_q    <= 1'b1;
            end else begin
              err_o       <= 1'b1;
              lock_o      <= 1'b0;
              last_qual_q <= 1'b0;
              state_q     <= ACQ;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
